// File: rtl/int_to_float.sv
// int_to_float: 32-bit two's-complement integer to IEEE-754 single precision,
// round to nearest, ties to even. One operand in flight; multi-cycle
// normalisation shifts one bit per cycle.
//
// Handshake (both sides, stb/ack): a word moves on a rising edge where the
// sender's stb and the receiver's ack are both 1. The sender holds data and
// stb stable until that edge; stb or ack seen alone is ignored.
module int_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic [2:0]  o_state
);

  localparam logic [2:0] S_GET_A     = 3'd0;
  localparam logic [2:0] S_CONVERT_0 = 3'd1;
  localparam logic [2:0] S_NORMALISE = 3'd2;
  localparam logic [2:0] S_ROUND     = 3'd3;
  localparam logic [2:0] S_PACK      = 3'd4;
  localparam logic [2:0] S_PUT_Z     = 3'd5;

  logic [2:0]  r_state;
  logic [31:0] r_a;
  logic        r_sign;
  logic [31:0] r_m;
  logic [7:0]  r_e;
  logic [23:0] r_mant;
  logic [31:0] r_z;
  logic        r_z_stb;
  logic        r_a_ack;

  logic [31:0] w_abs;
  logic        w_guard;
  logic        w_round;
  logic        w_sticky;
  logic        w_round_up;
  logic [24:0] w_mant_inc;

  // Magnitude of the captured operand; -2^31 maps to 0x80000000 naturally.
  assign w_abs      = r_a[31] ? (~r_a + 32'd1) : r_a;

  // Rounding terms taken from the normalised magnitude (bit 31 set).
  assign w_guard    = r_m[7];
  assign w_round    = r_m[6];
  assign w_sticky   = |r_m[5:0];
  assign w_round_up = w_guard & (w_round | w_sticky | r_m[8]);
  assign w_mant_inc = {1'b0, r_m[31:8]} + 25'd1;

  // Conversion FSM: capture, take magnitude, normalise, round, pack, hand off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_GET_A;
      r_a     <= 32'd0;
      r_sign  <= 1'b0;
      r_m     <= 32'd0;
      r_e     <= 8'd0;
      r_mant  <= 24'd0;
      r_z     <= 32'd0;
      r_z_stb <= 1'b0;
      r_a_ack <= 1'b0;
    end else begin
      case (r_state)
        S_GET_A: begin
          if (!r_a_ack) begin
            r_a_ack <= 1'b1;
          end else if (input_a_stb) begin
            r_a     <= input_a;
            r_a_ack <= 1'b0;
            r_state <= S_CONVERT_0;
          end
        end
        S_CONVERT_0: begin
          r_sign <= r_a[31];
          r_m    <= w_abs;
          r_e    <= 8'd31;
          if (r_a == 32'd0) begin
            // Zero has no leading one; it bypasses the datapath entirely.
            r_z     <= 32'd0;
            r_z_stb <= 1'b1;
            r_state <= S_PUT_Z;
          end else begin
            r_state <= S_NORMALISE;
          end
        end
        S_NORMALISE: begin
          if (!r_m[31]) begin
            r_m <= r_m << 1;
            r_e <= r_e - 8'd1;
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (w_round_up) begin
            if (w_mant_inc[24]) begin
              // 0xFFFFFF rounded up becomes 1.0 x 2^(e+1).
              r_mant <= 24'h800000;
              r_e    <= r_e + 8'd1;
            end else begin
              r_mant <= w_mant_inc[23:0];
            end
          end else begin
            r_mant <= r_m[31:8];
          end
          r_state <= S_PACK;
        end
        S_PACK: begin
          // Exponent is at most 31, so the biased value never overflows.
          r_z     <= {r_sign, r_e + 8'd127, r_mant[22:0]};
          r_z_stb <= 1'b1;
          r_state <= S_PUT_Z;
        end
        S_PUT_Z: begin
          if (output_z_ack) begin
            r_z_stb <= 1'b0;
            r_a_ack <= 1'b1;
            r_state <= S_GET_A;
          end
        end
        default: begin
          r_state <= S_GET_A;
        end
      endcase
    end
  end

  assign input_a_ack  = r_a_ack;
  assign output_z     = r_z;
  assign output_z_stb = r_z_stb;
  assign o_state      = r_state;

endmodule
